ram_bubble_sort: RTL and testbench



---
 rtl/ram_bubble_sort.sv | 188 ++++++++++++++++++
 tb/tb_ram_bubble_sort.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/ram_bubble_sort.sv
// In-place ascending bubble sort of a DEPTH x DATA_W single-port RAM with
// early termination; the pass window shrinks by one word after each pass.
module ram_bubble_sort #(
    parameter int DEPTH       = 32,
    parameter int ADDR_W      = 5,
    parameter int DATA_W      = 8,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] ram_out,
    output logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] data,
    output logic              wren,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] pass_count,
    output logic [8:0]        swap_count
);

    localparam int WAIT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

    typedef enum logic [3:0] {
        IDLE, RD_A, WAIT_A, RD_B, WAIT_B, CMP, WR_A, WR_B, NEXT, DONE
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   i_q, i_d;
    logic [ADDR_W-1:0]   last_q, last_d;
    logic [DATA_W-1:0]   va_q, va_d;
    logic [DATA_W-1:0]   vb_q, vb_d;
    logic                swapped_q, swapped_d;
    logic [WAIT_W-1:0]   wait_q, wait_d;
    logic [ADDR_W-1:0]   address_q, address_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                wren_q, wren_d;
    logic [ADDR_W-1:0]   pass_q, pass_d;
    logic [8:0]          swap_q, swap_d;
    logic                wait_last;

    assign wait_last = (wait_q == WAIT_W'(WAIT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            i_q       <= '0;
            last_q    <= '0;
            va_q      <= '0;
            vb_q      <= '0;
            swapped_q <= 1'b0;
            wait_q    <= '0;
            address_q <= '0;
            data_q    <= '0;
            wren_q    <= 1'b0;
            pass_q    <= '0;
            swap_q    <= '0;
        end else begin
            state_q   <= state_d;
            i_q       <= i_d;
            last_q    <= last_d;
            va_q      <= va_d;
            vb_q      <= vb_d;
            swapped_q <= swapped_d;
            wait_q    <= wait_d;
            address_q <= address_d;
            data_q    <= data_d;
            wren_q    <= wren_d;
            pass_q    <= pass_d;
            swap_q    <= swap_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        i_d       = i_q;
        last_d    = last_q;
        va_d      = va_q;
        vb_d      = vb_q;
        swapped_d = swapped_q;
        wait_d    = wait_q;
        address_d = address_q;
        data_d    = data_q;
        wren_d    = 1'b0;
        pass_d    = pass_q;
        swap_d    = swap_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    i_d       = '0;
                    last_d    = ADDR_W'(DEPTH - 2);
                    swapped_d = 1'b0;
                    pass_d    = '0;
                    swap_d    = '0;
                    state_d   = RD_A;
                end
            end
            RD_A: begin
                address_d = i_q;
                wait_d    = '0;
                state_d   = WAIT_A;
            end
            WAIT_A: begin
                if (wait_last) begin
                    va_d    = ram_out;
                    state_d = RD_B;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            RD_B: begin
                address_d = i_q + 1'b1;
                wait_d    = '0;
                state_d   = WAIT_B;
            end
            WAIT_B: begin
                if (wait_last) begin
                    vb_d    = ram_out;
                    state_d = CMP;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            CMP: begin
                // The first write is launched here so wren is high while in WR_A.
                if (va_q > vb_q) begin
                    swapped_d = 1'b1;
                    swap_d    = swap_q + 1'b1;
                    address_d = i_q;
                    data_d    = vb_q;
                    wren_d    = 1'b1;
                    state_d   = WR_A;
                end else begin
                    state_d = NEXT;
                end
            end
            WR_A: begin
                address_d = i_q + 1'b1;
                data_d    = va_q;
                wren_d    = 1'b1;
                state_d   = WR_B;
            end
            WR_B: begin
                state_d = NEXT;
            end
            NEXT: begin
                if (i_q < last_q) begin
                    i_d     = i_q + 1'b1;
                    state_d = RD_A;
                end else begin
                    pass_d = pass_q + 1'b1;
                    if (!swapped_q || (last_q == '0)) begin
                        state_d = DONE;
                    end else begin
                        last_d    = last_q - 1'b1;
                        i_d       = '0;
                        swapped_d = 1'b0;
                        state_d   = RD_A;
                    end
                end
            end
            DONE: begin
                if (!start) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign address    = address_q;
    assign data       = data_q;
    assign wren       = wren_q;
    assign busy       = (state_q != IDLE) && (state_q != DONE);
    assign done       = (state_q == DONE);
    assign pass_count = pass_q;
    assign swap_count = swap_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (!wren_q || state_q == WR_A || state_q == WR_B);
            assert (!(done && busy));
        end
    end

endmodule

// File: tb/tb_ram_bubble_sort.sv
// Random and directed sorts against a RAM model; a scoreboard of expected
// sorted contents and pass/swap counts is checked whenever done rises.
module tb_ram_bubble_sort;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] ram_out;
    logic [4:0] address;
    logic [7:0] data;
    logic       wren;
    logic       busy;
    logic       done;
    logic [4:0] pass_count;
    logic [8:0] swap_count;

    always #5 clk = ~clk;

    ram_bubble_sort dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .ram_out    (ram_out),
        .address    (address),
        .data       (data),
        .wren       (wren),
        .busy       (busy),
        .done       (done),
        .pass_count (pass_count),
        .swap_count (swap_count)
    );

    // RAM with registered address, combinational read of the registered address
    logic [7:0] mem [32];
    logic [7:0] load_img [32];
    logic       load_en = 1'b0;
    logic [4:0] ram_addr_q = '0;

    always @(posedge clk) begin
        ram_addr_q <= address;
        if (load_en) begin
            for (int k = 0; k < 32; k++) mem[k] <= load_img[k];
        end else if (wren) begin
            mem[address] <= data;
        end
    end
    assign ram_out = mem[ram_addr_q];

    typedef struct {
        logic [7:0] arr [32];
        int         passes;
        int         swaps;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   wr_count = 0;
    int   sort_no  = 0;
    logic done_prev = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Swaps equal the inversion count; passes follow from the largest number
    // of bigger words sitting in front of any word, plus the clean pass.
    function automatic exp_t model(input logic [7:0] a [32]);
        exp_t e;
        int   q[$];
        int   maxinv = 0;
        e.swaps = 0;
        for (int k = 0; k < 32; k++) begin
            int cnt = 0;
            for (int j = 0; j < k; j++) if (a[j] > a[k]) cnt++;
            e.swaps += cnt;
            if (cnt > maxinv) maxinv = cnt;
            q.push_back(int'(a[k]));
        end
        q.sort();
        for (int k = 0; k < 32; k++) e.arr[k] = q[k][7:0];
        e.passes = (maxinv + 1 > 31) ? 31 : maxinv + 1;
        return e;
    endfunction

    always @(negedge clk) begin
        if (wren) wr_count++;
        if (done && !done_prev) begin
            if (sb_q.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                int bad = 0;
                mon_e = sb_q.pop_front();
                for (int k = 0; k < 32; k++) if (mem[k] !== mon_e.arr[k]) bad++;
                check("pass_count", 32'(pass_count), 32'(mon_e.passes));
                check("swap_count", 32'(swap_count), 32'(mon_e.swaps));
                check("write_count", 32'(wr_count), 32'(2 * mon_e.swaps));
                check("mem_sorted_mismatches", 32'(bad), 32'd0);
                $display("sort %0d: passes=%0d/%0d swaps=%0d/%0d writes=%0d bad_words=%0d",
                         sort_no, pass_count, mon_e.passes, swap_count, mon_e.swaps, wr_count, bad);
                sort_no++;
            end
        end
        done_prev = done;
    end

    task automatic load_ram();
        @(negedge clk) load_en = 1'b1;
        @(negedge clk) load_en = 1'b0;
    endtask

    task automatic run_sort(input bit from_img);
        int cyc = 0;
        if (from_img) begin
            load_ram();
            sb_q.push_back(model(load_img));
        end else begin
            sb_q.push_back(model(mem));
        end
        wr_count = 0;
        start = 1'b1;
        @(negedge clk);
        while (!done && cyc < 20000) begin
            @(negedge clk);
            cyc++;
        end
        if (!done) begin
            check("done_timeout", 32'd0, 32'd1);
            void'(sb_q.pop_back());
        end
        repeat (10) begin
            @(negedge clk);
            check("done_held", 32'(done), 32'd1);
            check("no_wren_in_done", 32'(wren), 32'd0);
        end
        start = 1'b0;
        @(negedge clk);
        check("done_fall", 32'(done), 32'd0);
        check("idle_not_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        int cyc;
        reset = 1'b1;
        start = 1'b0;
        for (int k = 0; k < 32; k++) load_img[k] = 8'(k);
        repeat (3) @(negedge clk);
        check("rst_address", 32'(address), 32'd0);
        check("rst_data", 32'(data), 32'd0);
        check("rst_wren", 32'(wren), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_pass", 32'(pass_count), 32'd0);
        check("rst_swap", 32'(swap_count), 32'd0);
        reset = 1'b0;

        for (int k = 0; k < 32; k++) load_img[k] = 8'(k);
        run_sort(1'b1);
        for (int k = 0; k < 32; k++) load_img[k] = 8'(31 - k);
        run_sort(1'b1);
        for (int k = 0; k < 32; k++) load_img[k] = 8'd7;
        run_sort(1'b1);
        for (int k = 0; k < 32; k++) load_img[k] = (k == 0) ? 8'd200 : 8'(k);
        run_sort(1'b1);
        for (int t = 0; t < 4; t++) begin
            for (int k = 0; k < 32; k++)
                load_img[k] = (t == 3) ? 8'($urandom_range(0, 3)) : 8'($urandom_range(0, 255));
            run_sort(1'b1);
        end

        // Abort the descending sort during its first swap write.
        for (int k = 0; k < 32; k++) load_img[k] = 8'(31 - k);
        load_ram();
        sb_q.push_back(model(load_img));
        wr_count = 0;
        start = 1'b1;
        cyc = 0;
        @(negedge clk);
        while (!wren && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        check("first_swap_seen", 32'(wren), 32'd1);
        check("first_swap_addr", 32'(address), 32'd0);
        reset = 1'b1;
        start = 1'b0;
        @(negedge clk);
        void'(sb_q.pop_back());
        check("midrst_wren", 32'(wren), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        check("midrst_pass", 32'(pass_count), 32'd0);
        check("midrst_swap", 32'(swap_count), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        run_sort(1'b0);

        repeat (3) @(negedge clk);
        check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
